// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM arbiter and controller: default widths,
// the arbiter state encoding and the command encodings on the controller port.
package sdram_pkg;
  localparam int ADDR_W_DEF = 26;
  localparam int DATA_W_DEF = 16;

  typedef enum logic {IDLE, ISSUE} arb_state_e;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10
  } sdram_cmd_e;

  function automatic sdram_cmd_e cmd_of(input logic we);
    return we ? CMD_WRITE : CMD_READ;
  endfunction
endpackage

// File: rtl/sdram_tag_fifo.sv
// In-order tag FIFO: records which requester owns each outstanding read.
// A push at full is accepted when a pop happens in the same cycle.
module sdram_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller command port between
// NUM_REQ requesters; read data is steered back via an in-order tag FIFO.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int RD_DEPTH = 4,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_data_write,
  input  logic                      mem_ready,
  input  logic [DATA_W-1:0]         mem_data_read,
  input  logic                      mem_data_read_val,
  output logic                      err_orphan
);
  localparam int TAG_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(RD_DEPTH) + 1;

  arb_state_e       state;
  sdram_cmd_e       cmd;
  logic [TAG_W-1:0] grant, rr_ptr, pick, head;
  logic             pick_vld, accept, push, pop, full, empty, rd_ok;
  logic [CNT_W-1:0] count;
  logic [NUM_REQ-1:0] elig;

  // Eligibility uses the registered count: a same-cycle pop frees the slot next cycle.
  assign rd_ok = (count < CNT_W'(RD_DEPTH));
  assign elig  = req & (req_we | {NUM_REQ{rd_ok}});

  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!pick_vld && elig[idx]) begin
        pick_vld = 1'b1;
        pick     = TAG_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      grant          <= '0;
      rr_ptr         <= TAG_W'(NUM_REQ-1);
      cmd            <= CMD_NOP;
      mem_addr       <= '0;
      mem_data_write <= '0;
      err_orphan     <= 1'b0;
    end else begin
      if (mem_data_read_val && empty) err_orphan <= 1'b1;
      case (state)
        IDLE: if (pick_vld) begin
          grant          <= pick;
          cmd            <= cmd_of(req_we[pick]);
          mem_addr       <= req_addr[pick*ADDR_W +: ADDR_W];
          mem_data_write <= req_wdata[pick*DATA_W +: DATA_W];
          state          <= ISSUE;
        end
        ISSUE: if (mem_ready) begin
          rr_ptr         <= grant;
          cmd            <= CMD_NOP;
          mem_addr       <= '0;
          mem_data_write <= '0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_read  = (cmd == CMD_READ);
  assign mem_write = (cmd == CMD_WRITE);
  assign accept    = (state == ISSUE) & mem_ready;
  assign push      = accept & mem_read & (~full | pop);
  assign pop       = mem_data_read_val & ~empty;
  assign rdata     = mem_data_read;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign ack[i]    = accept & (grant == TAG_W'(i));
    assign rvalid[i] = pop & (head == TAG_W'(i));
  end

  sdram_tag_fifo #(.WIDTH(TAG_W), .DEPTH(RD_DEPTH)) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (grant),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );
endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller command port between NUM_REQ independent requesters, e.g. CPU, video fetch and DMA.
- Arbitration is round-robin, and the arbiter holds each command until the controller accepts it.
- Every accepted read is tagged with its requester ID in an in-order tag FIFO, so returning read data is steered back to its owner.
- Sits between SoC masters and the SDRAM controller.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- RD_DEPTH, 4, max in-flight reads (tag FIFO depth, power of 2).
- ADDR_W, 26, address width {chip, bank[1:0], row[12:0], col[9:0]}.
- DATA_W, 16, data width.

Ports:
- clk  in  1  system clock; SDRAM controller shares it.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req  in  NUM_REQ  per-requester command request; held until ack.
- req_we  in  NUM_REQ  1 = write, 0 = read, per requester.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies slice i.
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- ack  out  NUM_REQ  one-cycle pulse: command accepted by the controller.
- rdata  out  DATA_W  read data, broadcast to all requesters.
- rvalid  out  NUM_REQ  rdata valid for requester i.
- mem_read  out  1  read command to the controller.
- mem_write  out  1  write command to the controller.
- mem_addr  out  ADDR_W  command address.
- mem_data_write  out  DATA_W  write data.
- mem_ready  in  1  controller samples the command this cycle.
- mem_data_read  in  DATA_W  read data from the controller.
- mem_data_read_val  in  1  read data valid; returns in command order.
- err_orphan  out  1  sticky: read data arrived with no outstanding tag.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; rr_ptr=NUM_REQ-1; tag FIFO empty; err_orphan=0.
  - All outputs 0: mem_read, mem_write, mem_addr, mem_data_write, ack, rvalid.
- Eligibility:
  - Write requests are always eligible.
  - A read (req[i] & ~req_we[i]) is eligible only if the tag FIFO count < RD_DEPTH.
- FSM, states IDLE and ISSUE:
  - IDLE, any eligible request: pick the first eligible index searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ. Register grant=g and load mem_read/mem_write/mem_addr/mem_data_write from requester g. Next state ISSUE.
  - IDLE, no eligible request: command outputs stay 0.
  - ISSUE: command outputs held stable. When mem_ready=1 the command is accepted:
    - ack[g]=1 that same cycle (combinational from state, grant and mem_ready).
    - rr_ptr<=g.
    - If the command is a read, push g into the tag FIFO.
    - Command outputs clear next cycle. Next state IDLE.
  - ISSUE with mem_ready=0: stay in ISSUE indefinitely; no timeout.
- Throughput and latency:
  - Max one command per 2 cycles.
  - Minimum latency from req assertion to ack is 2 cycles: IDLE sample, then ISSUE with mem_ready=1.
- Request stability:
  - Requesters must hold req, req_we, req_addr and req_wdata stable until ack.
  - Deasserting req before ack is illegal. The latched command is still issued.
- Read return:
  - rdata = mem_data_read (combinational).
  - rvalid[i] = mem_data_read_val & FIFO-not-empty & (head == i).
  - The FIFO pops on mem_data_read_val.
  - Push and pop in the same cycle: count unchanged, and head/tail both advance correctly. This works even at full, because a pop frees a slot.
  - Full-FIFO eligibility is evaluated on the registered count. A pop in the same cycle does not make a read eligible until the next cycle.
- Orphan data: mem_data_read_val with the FIFO empty sets err_orphan=1 until reset; no rvalid is raised and no pop occurs.
- Fairness: a requester holding req continuously is granted within NUM_REQ commands, except that a blocked read waits on outstanding reads to drain.
- Widths: tag width = $clog2(NUM_REQ); count width = $clog2(RD_DEPTH)+1; FIFO pointers wrap modulo RD_DEPTH.
- Reset mid-ISSUE: the command is dropped, no ack is issued, and in-flight tags are lost.

Decomposition:
- Package sdram_pkg holds:
  - ADDR_W and DATA_W defaults;
  - the arbiter state enum {IDLE, ISSUE};
  - the SDRAM command encodings, shared with the controller.
- Sub-module sdram_tag_fifo: a parameterized synchronous FIFO (WIDTH, DEPTH) with push, pop, head, count, full and empty. It uses the same clk and reset.

Test Plan:
- Single write: req[1]=1, we, addr=0x0123456, wdata=0xBEEF, mem_ready=1 in ISSUE.
  - Expect mem_write=1 with mem_addr=0x0123456 and mem_data_write=0xBEEF.
  - Expect ack[1] pulse 2 cycles after req, and no tag pushed.
- Round-robin: all 4 requesting writes continuously, mem_ready=1.
  - Grant order must be 0,1,2,3,0,…, with ack every 2nd cycle.
- Read steering: reads from req2 then req0 accepted; mem_data_read_val pulses with 0x1111 then 0x2222.
  - Expect rvalid[2] with rdata=0x1111, then rvalid[0] with 0x2222.
- Backpressure and full FIFO:
  - Hold mem_ready=0 for 5 cycles: command outputs must stay stable and no ack may fire.
  - Issue 4 reads with no returns: a 5th read must not be granted while a pending write from another requester is granted.
  - After one return, the 5th read is granted next IDLE.
- Orphan and reset: mem_data_read_val with FIFO empty must set err_orphan and raise no rvalid.
  - Assert reset=0 asynchronously mid-ISSUE: all outputs go 0 immediately and err_orphan clears.
